// File: rtl/addr_xlate_pkg.sv
// Shared constants for the router address translation table.
// The optional reverse (physical->logical) lookup is enabled with ADDR_XLATE_REVERSE_EN.
package addr_xlate_pkg;

    localparam logic XLATE_DIR_L2P         = 1'b0;
    localparam logic XLATE_DIR_P2L         = 1'b1;
    localparam logic XLATE_MODE_TRANSLATE  = 1'b0;
    localparam logic XLATE_MODE_BYPASS     = 1'b1;

endpackage

// File: rtl/addr_xlate_match.sv
// Combinational lowest-index priority compare of a key against every table entry.
// idx is 0 and hit is 0 when no entry matches.
module addr_xlate_match
    import addr_xlate_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_ROUTERS = 16
) (
    input  logic [NUM_ROUTERS-1:0][ADDR_WIDTH-1:0] entries,
    input  logic [ADDR_WIDTH-1:0]                  key,
    output logic [ADDR_WIDTH-1:0]                  idx,
    output logic                                   hit
);

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = NUM_ROUTERS - 1; i >= 0; i--) begin
            if (entries[i] == key) begin
                idx = ADDR_WIDTH'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/addr_xlate_table.sv
// Programmable logical/physical router address translation table with a two-stage lookup pipeline.
// Define ADDR_XLATE_REVERSE_EN to add the req_dir port and physical->logical lookups.
module addr_xlate_table
    import addr_xlate_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int NUM_ROUTERS    = 16,
    parameter int MISS_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [ADDR_WIDTH-1:0]     cfg_idx,
    input  logic [ADDR_WIDTH-1:0]     cfg_data,
    input  logic                      cfg_mode_we,
    input  logic                      cfg_mode,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
`ifdef ADDR_XLATE_REVERSE_EN
    input  logic                      req_dir,
`endif
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ADDR_WIDTH-1:0]     rsp_addr,
    output logic                      rsp_hit,
    output logic                      mode,
    output logic [MISS_CNT_WIDTH-1:0] miss_count
);

    logic [NUM_ROUTERS-1:0][ADDR_WIDTH-1:0] tbl;
    logic                                   mode_q;

    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
`ifdef ADDR_XLATE_REVERSE_EN
    logic                  s1_dir;
`endif

    logic                      s2_valid;
    logic [ADDR_WIDTH-1:0]     s2_addr;
    logic                      s2_hit;
    logic [MISS_CNT_WIDTH-1:0] miss_q;

    logic                  s2_adv;
    logic [ADDR_WIDTH-1:0] match_idx;
    logic                  match_hit;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic                  nxt_hit;

    // Table and mode are ordinary registers, so a write becomes visible to the
    // S1->S2 transfer one cycle later; a transfer in the write cycle sees old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROUTERS; i++) begin
                tbl[i] <= ADDR_WIDTH'(i);
            end
            mode_q <= XLATE_MODE_TRANSLATE;
        end else begin
            if (cfg_we && (32'(cfg_idx) < NUM_ROUTERS)) begin
                tbl[cfg_idx] <= cfg_data;
            end
            if (cfg_mode_we) begin
                mode_q <= cfg_mode;
            end
        end
    end

    addr_xlate_match #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_ROUTERS (NUM_ROUTERS)
    ) u_match (
        .entries (tbl),
        .key     (s1_addr),
        .idx     (match_idx),
        .hit     (match_hit)
    );

    always_comb begin
        nxt_addr = match_idx;
        nxt_hit  = match_hit;
`ifdef ADDR_XLATE_REVERSE_EN
        if (s1_dir == XLATE_DIR_P2L) begin
            if (32'(s1_addr) < NUM_ROUTERS) begin
                nxt_addr = tbl[s1_addr];
                nxt_hit  = 1'b1;
            end else begin
                nxt_addr = '0;
                nxt_hit  = 1'b0;
            end
        end
`endif
        if (mode_q == XLATE_MODE_BYPASS) begin
            nxt_addr = s1_addr;
            nxt_hit  = 1'b1;
        end
    end

    // Handshakes: a beat moves on a clock edge where valid & ready are both high;
    // a held valid keeps its payload unchanged until ready; ready may depend
    // combinationally on the downstream ready but valid never depends on ready.
    assign s2_adv    = !s2_valid || rsp_ready;
    assign req_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
`ifdef ADDR_XLATE_REVERSE_EN
            s1_dir   <= XLATE_DIR_L2P;
`endif
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_hit   <= 1'b0;
            miss_q   <= '0;
        end else begin
            if (req_ready) begin
                s1_valid <= req_valid;
                if (req_valid) begin
                    s1_addr <= req_addr;
`ifdef ADDR_XLATE_REVERSE_EN
                    s1_dir  <= req_dir;
`endif
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_addr <= nxt_addr;
                    s2_hit  <= nxt_hit;
                end
            end
            if (s2_valid && rsp_ready && !s2_hit && (miss_q != '1)) begin
                miss_q <= miss_q + MISS_CNT_WIDTH'(1);
            end
        end
    end

    assign rsp_valid  = s2_valid;
    assign rsp_addr   = s2_addr;
    assign rsp_hit    = s2_hit;
    assign mode       = mode_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_addr_xlate_table.sv
// Self-checking bench for addr_xlate_table: vector table plus scoreboard queue and
// hand-written sequences for stall, config race, bypass and mid-stream reset.
module tb_addr_xlate_table;
    import addr_xlate_pkg::*;

    localparam int AW = 4;
    localparam int NR = 16;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_idx;
    logic [AW-1:0] cfg_data;
    logic          cfg_mode_we;
    logic          cfg_mode;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
`ifdef ADDR_XLATE_REVERSE_EN
    logic          req_dir;
`endif
    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic          rsp_hit;
    logic          mode;
    logic [MW-1:0] miss_count;

    int checks = 0;
    int errors = 0;
    logic [AW:0] exp_q[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] exp_addr;
        logic          exp_hit;
    } vec_t;
    vec_t vecs[8];

    addr_xlate_table #(
        .ADDR_WIDTH     (AW),
        .NUM_ROUTERS    (NR),
        .MISS_CNT_WIDTH (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_data    (cfg_data),
        .cfg_mode_we (cfg_mode_we),
        .cfg_mode    (cfg_mode),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
`ifdef ADDR_XLATE_REVERSE_EN
        .req_dir     (req_dir),
`endif
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_addr    (rsp_addr),
        .rsp_hit     (rsp_hit),
        .mode        (mode),
        .miss_count  (miss_count)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare each delivered response against the oldest expectation
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got addr %0h hit %0b expected no response", rsp_addr, rsp_hit);
            end else begin
                logic [AW:0] e;
                e = exp_q.pop_front();
                check("rsp_addr", 32'(rsp_addr), 32'(e[AW:1]));
                check("rsp_hit", 32'(rsp_hit), 32'(e[0]));
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept_and_push(input logic [AW-1:0] ea, input logic eh);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL req_ready_timeout: got req_ready 0 for %0d cycles expected 1", n);
                break;
            end
        end
        exp_q.push_back({ea, eh});
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] ea, input logic eh);
        req_valid = 1'b1;
        req_addr  = a;
`ifdef ADDR_XLATE_REVERSE_EN
        req_dir   = XLATE_DIR_L2P;
`endif
        accept_and_push(ea, eh);
    endtask

`ifdef ADDR_XLATE_REVERSE_EN
    task automatic send_p2l(input logic [AW-1:0] a, input logic [AW-1:0] ea, input logic eh);
        req_valid = 1'b1;
        req_addr  = a;
        req_dir   = XLATE_DIR_P2L;
        accept_and_push(ea, eh);
    endtask
`endif

    task automatic cfg_write(input logic [AW-1:0] idx, input logic [AW-1:0] data);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_data = data;
        tick(1);
        cfg_we   = 1'b0;
    endtask

    task automatic set_mode(input logic m);
        cfg_mode_we = 1'b1;
        cfg_mode    = m;
        tick(1);
        cfg_mode_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
                break;
            end
        end
        tick(1);
    endtask

    // Main test sequence
    initial begin
        logic          saw_not_ready;
        logic [AW-1:0] cap_addr;
        logic          cap_hit;

        // Table after setup writes (3,5,7,12 -> 9):
        // 0 1 2 9 4 9 6 9 8 9 10 11 9 13 14 15
        vecs[0] = '{4'd9,  4'd3,  1'b1};
        vecs[1] = '{4'd5,  4'd0,  1'b0};
        vecs[2] = '{4'd0,  4'd0,  1'b1};
        vecs[3] = '{4'd15, 4'd15, 1'b1};
        vecs[4] = '{4'd4,  4'd4,  1'b1};
        vecs[5] = '{4'd12, 4'd0,  1'b0};
        vecs[6] = '{4'd3,  4'd0,  1'b0};
        vecs[7] = '{4'd11, 4'd11, 1'b1};

        rst         = 1'b1;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_data    = '0;
        cfg_mode_we = 1'b0;
        cfg_mode    = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
`ifdef ADDR_XLATE_REVERSE_EN
        req_dir     = XLATE_DIR_L2P;
`endif
        rsp_ready   = 1'b1;
        tick(2);
        rst = 1'b0;

        check("reset_req_ready", 32'(req_ready), 1);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_addr", 32'(rsp_addr), 0);
        check("reset_rsp_hit", 32'(rsp_hit), 0);
        check("reset_mode", 32'(mode), 0);
        check("reset_miss_count", 32'(miss_count), 0);

        // Identity lookup and two-cycle latency
        send(4'd5, 4'd5, 1'b1);
        check("latency_n1_rsp_valid", 32'(rsp_valid), 0);
        tick(1);
        check("latency_n2_rsp_valid", 32'(rsp_valid), 1);
        drain();

        // Duplicates: lowest index wins; overwritten entry now misses
        cfg_write(4'd3, 4'd9);
        cfg_write(4'd7, 4'd9);
        cfg_write(4'd5, 4'd9);
        cfg_write(4'd12, 4'd9);
        send(4'd9, 4'd3, 1'b1);
        send(4'd5, 4'd0, 1'b0);
        drain();
        check("miss_count_first", 32'(miss_count), 1);

        // Vector table, then saturation after four misses in total
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].addr, vecs[i].exp_addr, vecs[i].exp_hit);
        end
        drain();
        check("miss_count_saturated", 32'(miss_count), 3);

        // Back-to-back burst with a three-cycle response stall
        saw_not_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(vecs[7 - i].addr, vecs[7 - i].exp_addr, vecs[7 - i].exp_hit);
                end
            end
            begin
                tick(3);
                rsp_ready = 1'b0;
                @(negedge clk);
                cap_addr = rsp_addr;
                cap_hit  = rsp_hit;
                check("stall_rsp_valid", 32'(rsp_valid), 1);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (!req_ready) saw_not_ready = 1'b1;
                    check("stall_rsp_valid_held", 32'(rsp_valid), 1);
                    check("stall_rsp_addr_held", 32'(rsp_addr), 32'(cap_addr));
                    check("stall_rsp_hit_held", 32'(rsp_hit), 32'(cap_hit));
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        check("stall_req_ready_dropped", 32'(saw_not_ready), 1);
        drain();

        // Config write in the same cycle as the S1->S2 transfer uses old contents
        send(4'd12, 4'd0, 1'b0);
        cfg_we   = 1'b1;
        cfg_idx  = 4'd2;
        cfg_data = 4'd12;
        tick(1);
        cfg_we   = 1'b0;
        send(4'd12, 4'd2, 1'b1);
        drain();

        // Bypass mode
        set_mode(1'b1);
        check("mode_bypass", 32'(mode), 1);
        send(4'd14, 4'd14, 1'b1);
        send(4'd5, 4'd5, 1'b1);
        drain();
        set_mode(1'b0);
        check("mode_translate", 32'(mode), 0);

`ifdef ADDR_XLATE_REVERSE_EN
        send_p2l(4'd3, 4'd9, 1'b1);
        send_p2l(4'd2, 4'd12, 1'b1);
        send_p2l(4'd0, 4'd0, 1'b1);
        drain();
`endif

        // Reset with both stages full
        set_mode(1'b1);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 4'd0;
        tick(1);
        req_addr  = 4'd1;
        tick(1);
        req_valid = 1'b0;
        check("full_rsp_valid", 32'(rsp_valid), 1);
        check("full_req_ready", 32'(req_ready), 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midreset_rsp_valid", 32'(rsp_valid), 0);
        check("midreset_req_ready", 32'(req_ready), 1);
        check("midreset_mode", 32'(mode), 0);
        check("midreset_miss_count", 32'(miss_count), 0);
        rsp_ready = 1'b1;
        send(4'd9, 4'd9, 1'b1);
        send(4'd2, 4'd2, 1'b1);
        send(4'd12, 4'd12, 1'b1);
        drain();
        check("post_reset_miss_count", 32'(miss_count), 0);

        // Final report
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
